alu_rr_sequencer: RTL and testbench

Shares the single combinational n-bit ALU (a, b, 3-bit sel → s, co) between two requesters. Requests arrive over valid/ready handshakes and are arbitrated round-robin. The winner's operands and op-select are registered onto the ALU ports, and the result is captured one cycle later. The result is returned on a single response channel tagged with the requester id. The ALU itself is instantiated at the parent level and wired to the alu_* ports.

---
 rtl/alu_rr_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_sequencer.sv
// Round-robin sequencer sharing one external combinational ALU between two
// valid/ready requesters; results return on a single tagged response channel.
module alu_rr_sequencer #(
    parameter int n  = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [n-1:0]  req0_a,
    input  logic [n-1:0]  req0_b,
    input  logic [2:0]    req0_sel,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [n-1:0]  req1_a,
    input  logic [n-1:0]  req1_b,
    input  logic [2:0]    req1_sel,
    output logic          req1_ready,
    output logic [n-1:0]  alu_a,
    output logic [n-1:0]  alu_b,
    output logic [2:0]    alu_sel,
    input  logic [n-1:0]  alu_s,
    input  logic          alu_co,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [n-1:0]  rsp_s,
    output logic          rsp_co,
    output logic          busy,
    output logic [CW-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t        state_q, state_d;
    logic          last_id_q, last_id_d;
    logic          id_q, id_d;
    logic [n-1:0]  alu_a_q, alu_a_d;
    logic [n-1:0]  alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_id_q, rsp_id_d;
    logic [n-1:0]  rsp_s_q, rsp_s_d;
    logic          rsp_co_q, rsp_co_d;
    logic [CW-1:0] op_count_q, op_count_d;

    logic grant0, grant1;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid && (!req1_valid || last_id_q);
            grant1 = req1_valid && (!req0_valid || !last_id_q);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        id_d        = id_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_co_d    = rsp_co_q;
        op_count_d  = op_count_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    alu_a_d   = grant1 ? req1_a   : req0_a;
                    alu_b_d   = grant1 ? req1_b   : req0_b;
                    alu_sel_d = grant1 ? req1_sel : req0_sel;
                    id_d      = grant1;
                    last_id_d = grant1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rsp_s_d     = alu_s;
                rsp_co_d    = alu_co;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            id_q        <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_s_q     <= '0;
            rsp_co_q    <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            id_q        <= id_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_co_q    <= rsp_co_d;
            op_count_q  <= op_count_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_co    = rsp_co_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_alu_rr_sequencer.sv
// Directed bench for alu_rr_sequencer with a behavioural ALU stub and a
// response scoreboard; uses CW=2 so the op_count wrap is reachable.
module tb_alu_rr_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_sel, req1_sel;
    logic       req0_ready, req1_ready;
    logic [3:0] alu_a, alu_b, alu_s;
    logic [2:0] alu_sel;
    logic       alu_co;
    logic       rsp_valid, rsp_ready, rsp_id, rsp_co, busy;
    logic [3:0] rsp_s;
    logic [1:0] op_count;

    always #5 clk = ~clk;

    alu_rr_sequencer #(.n(4), .CW(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
        .req0_sel(req0_sel), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
        .req1_sel(req1_sel), .req1_ready(req1_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_s(alu_s), .alu_co(alu_co),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_s(rsp_s), .rsp_co(rsp_co), .busy(busy), .op_count(op_count)
    );

    function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
        case (sel)
            3'd0:    return {1'b0, a} + {1'b0, b};
            3'd1:    return {1'b0, a} - {1'b0, b};
            3'd2:    return {1'b0, a & b};
            3'd3:    return {1'b0, a | b};
            3'd4:    return {1'b0, a ^ b};
            3'd5:    return {1'b0, ~a};
            3'd6:    return {1'b0, a};
            default: return {1'b0, b};
        endcase
    endfunction

    // ALU stub; alu_force lets a test disturb the result while a response is held.
    logic       alu_force = 1'b0;
    logic [3:0] alu_force_val = 4'h0;
    always_comb begin
        {alu_co, alu_s} = ref_alu(alu_a, alu_b, alu_sel);
        if (alu_force) alu_s = alu_force_val;
    end

    typedef struct {
        logic       id;
        logic [3:0] s;
        logic       co;
    } exp_t;

    exp_t       sb[$];
    int         grants[$];
    int         acc_cyc[$];
    int         cnt_log[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc_n = 0;
    int         m_state = 0;
    logic       m_last = 1'b1;
    logic [1:0] m_count = 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0;
        m_last  = 1'b1;
        m_count = 2'd0;
        sb.delete();
    endtask

    // One clock: check outputs against the expectation model, then advance.
    task automatic cycle(input string tag);
        logic       e0, e1, acc, hs, wid;
        logic [3:0] wa, wb;
        logic [2:0] ws;
        logic [4:0] r;
        int         nxt;
        exp_t       e;
        #1;
        e0 = (m_state == 0) && req0_valid && (!req1_valid || m_last);
        e1 = (m_state == 0) && req1_valid && (!req0_valid || !m_last);
        chk({tag, ":req0_ready"}, req0_ready, e0);
        chk({tag, ":req1_ready"}, req1_ready, e1);
        chk({tag, ":busy"}, busy, m_state != 0);
        chk({tag, ":rsp_valid"}, rsp_valid, m_state == 2);
        chk({tag, ":op_count"}, op_count, m_count);
        if (m_state == 2) begin
            if (sb.size() == 0) chk({tag, ":rsp_unexpected"}, 1, 0);
            else begin
                chk({tag, ":rsp_id"}, rsp_id, sb[0].id);
                chk({tag, ":rsp_s"}, rsp_s, sb[0].s);
                chk({tag, ":rsp_co"}, rsp_co, sb[0].co);
            end
        end
        acc = e0 | e1;
        hs  = (m_state == 2) && rsp_ready;
        wid = e1;
        wa  = e1 ? req1_a : req0_a;
        wb  = e1 ? req1_b : req0_b;
        ws  = e1 ? req1_sel : req0_sel;
        nxt = m_state;
        if (acc) begin
            r = ref_alu(wa, wb, ws);
            e.id = wid; e.s = r[3:0]; e.co = r[4];
            sb.push_back(e);
            grants.push_back(int'(wid));
            acc_cyc.push_back(cyc_n);
            m_last = wid;
            nxt = 1;
        end else if (m_state == 1) nxt = 2;
        else if (hs) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_count = m_count + 2'd1;
            nxt = 0;
        end
        @(posedge clk);
        #1;
        cyc_n++;
        m_state = nxt;
        if (acc) begin
            chk({tag, ":alu_a"}, alu_a, wa);
            chk({tag, ":alu_b"}, alu_b, wb);
            chk({tag, ":alu_sel"}, alu_sel, ws);
        end
        if (hs) cnt_log.push_back(int'(op_count));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        grants.delete();
        acc_cyc.delete();
        cnt_log.delete();
    endtask

    initial begin
        int   budget;
        int   base;
        logic r0_seen;
        rst = 1'b1; rsp_ready = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;

        // Test 1: single op from requester 0, reset state first.
        do_reset();
        #1;
        chk("rst:alu_a", alu_a, 4'h0);
        chk("rst:alu_sel", alu_sel, 3'h0);
        chk("rst:rsp_valid", rsp_valid, 1'b0);
        chk("rst:rsp_s", rsp_s, 4'h0);
        chk("rst:busy", busy, 1'b0);
        chk("rst:op_count", op_count, 2'd0);
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5; req0_sel = 3'b000;
        cycle("t1_acc");
        req0_valid = 1'b0;
        chk("t1:alu_a", alu_a, 4'h3);
        chk("t1:alu_b", alu_b, 4'h5);
        cycle("t1_exec");
        chk("t1:rsp_valid", rsp_valid, 1'b1);
        chk("t1:rsp_id", rsp_id, 1'b0);
        chk("t1:rsp_s", rsp_s, 4'h8);
        cycle("t1_resp");
        chk("t1:op_count", op_count, 2'd1);
        chk("t1:rsp_valid_low", rsp_valid, 1'b0);

        // Test 2: both valid, round-robin alternation.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h1; req0_sel = 3'd0;
        req1_valid = 1'b1; req1_a = 4'h2; req1_b = 4'h2; req1_sel = 3'd0;
        budget = 40;
        while (cnt_log.size() < 4 && budget > 0) begin cycle("t2"); budget--; end
        if (budget == 0) chk("t2:timeout", 0, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (grants.size() >= 4) begin
            chk("t2:grant0", grants[0], 0);
            chk("t2:grant1", grants[1], 1);
            chk("t2:grant2", grants[2], 0);
            chk("t2:grant3", grants[3], 1);
            for (int i = 1; i < 4; i++) chk("t2:spacing", acc_cyc[i] - acc_cyc[i-1], 3);
        end else chk("t2:grant_count", grants.size(), 4);
        chk("t2:op_count_wrapped", op_count, 2'd0);

        // Test 3: only requester 1 valid.
        do_reset();
        req1_valid = 1'b1; req1_a = 4'hA; req1_b = 4'h7; req1_sel = 3'd1;
        r0_seen = 1'b0;
        budget = 40;
        while (cnt_log.size() < 3 && budget > 0) begin
            #1;
            if (req0_ready) r0_seen = 1'b1;
            cycle("t3");
            budget--;
        end
        if (budget == 0) chk("t3:timeout", 0, 1);
        req1_valid = 1'b0;
        chk("t3:req0_ready_seen", r0_seen, 1'b0);
        for (int i = 0; i < grants.size(); i++) chk("t3:grant", grants[i], 1);

        // Test 4: held response while ALU output changes.
        do_reset();
        rsp_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 4'h9; req0_b = 4'h4; req0_sel = 3'd0;
        cycle("t4_acc");
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 4'h6; req1_b = 4'h3; req1_sel = 3'd4;
        cycle("t4_exec");
        alu_force = 1'b1; alu_force_val = 4'hF;
        for (int i = 0; i < 5; i++) begin
            cycle("t4_hold");
            chk("t4:rsp_s_held", rsp_s, 4'hD);
        end
        alu_force = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        cycle("t4_release");
        chk("t4:busy_after", busy, 1'b0);
        chk("t4:op_count", op_count, 2'd1);

        // Test 5: reset during EXEC aborts the op.
        do_reset();
        req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'h5; req0_sel = 3'd3;
        cycle("t5_acc");
        req0_valid = 1'b0;
        chk("t5:in_exec", busy, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("t5:alu_a", alu_a, 4'h0);
        chk("t5:alu_sel", alu_sel, 3'h0);
        chk("t5:busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("t5:rsp_valid", rsp_valid, 1'b0);
        rst = 1'b0;
        model_clear();
        grants.delete();
        cycle("t5_idle");
        chk("t5:op_count", op_count, 2'd0);
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_a = 4'h1; req1_a = 4'h2;
        cycle("t5_tie");
        req0_valid = 1'b0; req1_valid = 1'b0;
        if (grants.size() == 1) chk("t5:tie_winner", grants[0], 0);
        else chk("t5:tie_grant_count", grants.size(), 1);
        cycle("t5_exec");
        cycle("t5_resp");

        // Test 6: op_count wrap, reserved sel codes passed through.
        do_reset();
        req0_valid = 1'b1;
        budget = 60;
        base = 0;
        req0_a = 4'h5; req0_b = 4'hB; req0_sel = 3'd3;
        while (cnt_log.size() < 5 && budget > 0) begin
            cycle("t6");
            if (grants.size() != base) begin
                base = grants.size();
                req0_a = req0_a + 4'h3; req0_b = req0_b - 4'h1; req0_sel = req0_sel + 3'd1;
            end
            budget--;
        end
        if (budget == 0) chk("t6:timeout", 0, 1);
        req0_valid = 1'b0;
        if (cnt_log.size() == 5) begin
            chk("t6:cnt0", cnt_log[0], 1);
            chk("t6:cnt1", cnt_log[1], 2);
            chk("t6:cnt2", cnt_log[2], 3);
            chk("t6:cnt3", cnt_log[3], 0);
            chk("t6:cnt4", cnt_log[4], 1);
        end else chk("t6:cnt_len", cnt_log.size(), 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
